// File: rtl/montgomery_pipe_stream.sv
// montgomery_pipe_stream: streaming 3-stage Montgomery reduction, res = x * R^-1 mod m with R = 2^rbits
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   cfg_we_i, cfg_m_i,            configuration load (m, -m^-1 mod R, log2 R); taken only when idle
//   cfg_minv_i, cfg_rbits_i
//   in_valid_i/in_ready_o,        operand stream (x < m*R) with user tag
//   in_x_i, in_tag_i
//   out_valid_o/out_ready_i,      result stream, tag travels with its result
//   out_res_o, out_tag_o
//   busy_o                        any stage holds valid data
// Optional: define MONTGOMERY_RANGE_CHECK_EN to add out_err_o, flagging x >= m*R (result forced to 0).
module montgomery_pipe_stream #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int RB_W   = $clog2(DATA_W) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cfg_we_i,
    input  logic [DATA_W-1:0]   cfg_m_i,
    input  logic [DATA_W-1:0]   cfg_minv_i,
    input  logic [RB_W-1:0]     cfg_rbits_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [2*DATA_W-1:0] in_x_i,
    input  logic [TAG_W-1:0]    in_tag_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_W-1:0]   out_res_o,
    output logic [TAG_W-1:0]    out_tag_o,
`ifdef MONTGOMERY_RANGE_CHECK_EN
    output logic                out_err_o,
`endif
    output logic                busy_o
);
    localparam int XW = 2 * DATA_W;

    logic [DATA_W-1:0] m, minv;
    logic [RB_W-1:0]   rbits;
    logic              v1, v2;
    logic [XW-1:0]     x1, x2;
    logic [TAG_W-1:0]  tag1, tag2;
    logic [DATA_W-1:0] q2;
    logic              adv, accept;
    logic [DATA_W-1:0] mask, xl, q, res;
    logic [XW:0]       s, t, mext;

    assign adv        = !out_valid_o || out_ready_i;
    assign in_ready_o = adv && !cfg_we_i;
    assign accept     = in_valid_i && in_ready_o;
    assign busy_o     = v1 || v2 || out_valid_o;

    // one spare bit so that rbits == DATA_W yields an all-ones mask
    assign mask = DATA_W'(((DATA_W + 1)'(1) << rbits) - (DATA_W + 1)'(1));
    assign xl   = x1[DATA_W-1:0] & mask;
    // only the low rbits of xl*minv matter, so a DATA_W-wide product suffices
    assign q    = (xl * minv) & mask;
    // x + q*m needs one bit above 2*DATA_W before the shift
    assign s    = (XW + 1)'(x2) + (XW + 1)'({{DATA_W{1'b0}}, q2} * {{DATA_W{1'b0}}, m});
    assign t    = s >> rbits;
    assign mext = (XW + 1)'(m);
    // t < 2m for in-range x, so one conditional subtract completes the reduction
    assign res  = DATA_W'(t >= mext ? t - mext : t);

`ifdef MONTGOMERY_RANGE_CHECK_EN
    logic e1, e2, err_in;
    assign err_in = (XW + 1)'(in_x_i) >= (mext << rbits);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            m           <= '0;
            minv        <= '0;
            rbits       <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            out_valid_o <= 1'b0;
            x1          <= '0;
            x2          <= '0;
            tag1        <= '0;
            tag2        <= '0;
            q2          <= '0;
            out_res_o   <= '0;
            out_tag_o   <= '0;
`ifdef MONTGOMERY_RANGE_CHECK_EN
            e1          <= 1'b0;
            e2          <= 1'b0;
            out_err_o   <= 1'b0;
`endif
        end else begin
            if (cfg_we_i && !busy_o) begin
                m     <= cfg_m_i;
                minv  <= cfg_minv_i;
                rbits <= cfg_rbits_i;
            end
            if (adv) begin
                v1          <= accept;
                v2          <= v1;
                out_valid_o <= v2;
                if (accept) begin
                    x1   <= in_x_i;
                    tag1 <= in_tag_i;
`ifdef MONTGOMERY_RANGE_CHECK_EN
                    e1   <= err_in;
`endif
                end
                if (v1) begin
                    x2   <= x1;
                    q2   <= q;
                    tag2 <= tag1;
`ifdef MONTGOMERY_RANGE_CHECK_EN
                    e2   <= e1;
`endif
                end
                if (v2) begin
                    out_tag_o <= tag2;
`ifdef MONTGOMERY_RANGE_CHECK_EN
                    out_res_o <= e2 ? '0 : res;
                    out_err_o <= e2;
`else
                    out_res_o <= res;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_montgomery_pipe_stream.sv
// tb_montgomery_pipe_stream: directed self-checking bench for montgomery_pipe_stream (no ports)
module tb_montgomery_pipe_stream;
    localparam int DW  = 32;
    localparam int TW  = 4;
    localparam int RBW = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_we = 1'b0;
    logic [DW-1:0]   cfg_m = '0;
    logic [DW-1:0]   cfg_minv = '0;
    logic [RBW-1:0]  cfg_rbits = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2*DW-1:0] in_x = '0;
    logic [TW-1:0]   in_tag = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   out_res;
    logic [TW-1:0]   out_tag;
    logic            busy;
`ifdef MONTGOMERY_RANGE_CHECK_EN
    logic            out_err;
    logic            err_q[$];
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int idx, k, lat;
    logic acc;
    logic [DW-1:0] res_q[$];
    logic [TW-1:0] tag_q[$];
    int            cyc_q[$];

    montgomery_pipe_stream #(.DATA_W(DW), .TAG_W(TW), .RB_W(RBW)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .cfg_we_i(cfg_we),
        .cfg_m_i(cfg_m),
        .cfg_minv_i(cfg_minv),
        .cfg_rbits_i(cfg_rbits),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .in_x_i(in_x),
        .in_tag_i(in_tag),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_res_o(out_res),
        .out_tag_o(out_tag),
`ifdef MONTGOMERY_RANGE_CHECK_EN
        .out_err_o(out_err),
`endif
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            res_q.push_back(out_res);
            tag_q.push_back(out_tag);
            cyc_q.push_back(cyc);
`ifdef MONTGOMERY_RANGE_CHECK_EN
            err_q.push_back(out_err);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic clear_q();
        res_q.delete();
        tag_q.delete();
        cyc_q.delete();
`ifdef MONTGOMERY_RANGE_CHECK_EN
        err_q.delete();
`endif
    endtask

    task automatic cfg(input logic [DW-1:0] mv, input logic [DW-1:0] minvv, input logic [RBW-1:0] rb);
        cfg_we = 1'b1;
        cfg_m = mv;
        cfg_minv = minvv;
        cfg_rbits = rb;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic send(input logic [2*DW-1:0] x, input logic [TW-1:0] t);
        int n = 0;
        in_valid = 1'b1;
        in_x = x;
        in_tag = t;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int c = 0;
        while (res_q.size() < n && c < 30) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("result_count", 64'(res_q.size()), 64'(n));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_res", 64'(out_res), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        cfg(32'd17, 32'd15, 6'd5);
        send(64'd100, 4'd3);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        check("latency", 64'(lat), 64'd3);
        check("single_res", 64'(out_res), 64'd1);
        check("single_tag", 64'(out_tag), 64'd3);
        @(posedge clk);
        #1 check("single_no_dup", 64'(out_valid), 64'd0);
        clear_q();
        send(64'd0, 4'd0);
        send(64'd543, 4'd1);
        send(64'd100, 4'd2);
        wait_out(3);
        check("b2b_res0", 64'(res_q[0]), 64'd0);
        check("b2b_res1", 64'(res_q[1]), 64'd9);
        check("b2b_res2", 64'(res_q[2]), 64'd1);
        check("b2b_tag0", 64'(tag_q[0]), 64'd0);
        check("b2b_tag1", 64'(tag_q[1]), 64'd1);
        check("b2b_tag2", 64'(tag_q[2]), 64'd2);
        check("b2b_gap01", 64'(cyc_q[1] - cyc_q[0]), 64'd1);
        check("b2b_gap12", 64'(cyc_q[2] - cyc_q[1]), 64'd1);
        clear_q();
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        in_x = 64'd1;
        in_tag = 4'd4;
        repeat (8) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc && idx < 4) begin
                idx++;
                in_x = 64'(idx + 1);
                in_tag = TW'(4 + idx);
            end
        end
        check("stall_accepted", 64'(idx), 64'd3);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_hold_res", 64'(out_res), 64'd8);
        check("stall_hold_tag", 64'(out_tag), 64'd4);
        check("stall_no_xfer", 64'(res_q.size()), 64'd0);
        out_ready = 1'b1;
        k = 0;
        while (idx < 4 && k < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                in_valid = 1'b0;
            end
            k++;
        end
        check("release_accepted", 64'(idx), 64'd4);
        wait_out(4);
        repeat (5) @(posedge clk);
        #1 check("release_no_dup", 64'(res_q.size()), 64'd4);
        check("release_res0", 64'(res_q[0]), 64'd8);
        check("release_res1", 64'(res_q[1]), 64'd16);
        check("release_res2", 64'(res_q[2]), 64'd7);
        check("release_res3", 64'(res_q[3]), 64'd15);
        check("release_tag0", 64'(tag_q[0]), 64'd4);
        check("release_tag3", 64'(tag_q[3]), 64'd7);
        clear_q();
        send(64'd100, 4'd9);
        send(64'd543, 4'd10);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_stale", 64'(res_q.size()), 64'd0);
        check("midrst_out_res", 64'(out_res), 64'd0);
        cfg(32'd17, 32'd15, 6'd5);
        clear_q();
        send(64'd100, 4'd1);
        check("cfgbusy_busy", 64'(busy), 64'd1);
        cfg_we = 1'b1;
        cfg_m = 32'd97;
        cfg_minv = 32'd95;
        cfg_rbits = 6'd7;
        #1 check("cfg_blocks_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        wait_out(1);
        check("cfgbusy_old_m_res", 64'(res_q[0]), 64'd1);
        check("cfgbusy_old_m_tag", 64'(tag_q[0]), 64'd1);
        k = 0;
        while (busy && k < 20) begin
            @(posedge clk);
            #1 k++;
        end
        check("idle_before_cfg", 64'(busy), 64'd0);
        cfg(32'd97, 32'd95, 6'd7);
        send(64'd200, 4'd2);
        wait_out(2);
        check("cfg97_res", 64'(res_q[1]), 64'd44);
        check("cfg97_tag", 64'(tag_q[1]), 64'd2);
        clear_q();
        cfg(32'hFFFF_FFFF, 32'd1, 6'd32);
        send(64'hFFFF_FFFE_FFFF_FFFF, 4'd11);
        send(64'd1, 4'd12);
        send(64'd0, 4'd13);
        wait_out(3);
        check("full_max_res", 64'(res_q[0]), 64'hFFFF_FFFE);
        check("full_one_res", 64'(res_q[1]), 64'd1);
        check("full_zero_res", 64'(res_q[2]), 64'd0);
        check("full_zero_tag", 64'(tag_q[2]), 64'd13);
`ifdef MONTGOMERY_RANGE_CHECK_EN
        clear_q();
        cfg(32'd17, 32'd15, 6'd5);
        send(64'd544, 4'd1);
        send(64'd543, 4'd2);
        wait_out(2);
        check("range_over_err", 64'(err_q[0]), 64'd1);
        check("range_over_res", 64'(res_q[0]), 64'd0);
        check("range_in_err", 64'(err_q[1]), 64'd0);
        check("range_in_res", 64'(res_q[1]), 64'd9);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
